// File: rtl/slave_out_port.sv
// Slave-side serial transmitter: fetches a burst from slave memory and shifts it out
// LSB-first on tx_data after an s_valid/m_ready handshake, prefetching each next word.
module slave_out_port #(
  parameter int WORD_SIZE  = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int BURST_SIZE = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [BURST_SIZE-1:0] burst_size,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [WORD_SIZE-1:0]  mem_rd_data,
  input  logic                  m_ready,
  output logic                  s_valid,
  output logic                  tx_data,
  output logic                  busy,
  output logic                  tx_done
);

  // state | meaning
  // IDLE  | waiting for start
  // FETCH | first word read in flight, waits for read data
  // VALID | word 0 loaded, s_valid held until m_ready
  // SEND  | shifting bits out, next word prefetched into next_buf
  typedef enum logic [1:0] {IDLE, FETCH, VALID, SEND} state_t;

  localparam int                   CW       = $clog2(WORD_SIZE);
  localparam logic [CW-1:0]         LAST_BIT = CW'(WORD_SIZE - 1);
  localparam logic [BURST_SIZE-1:0] ONE_B    = BURST_SIZE'(1);
  localparam logic [ADDR_WIDTH-1:0] ONE_A    = ADDR_WIDTH'(1);

  state_t                state;
  logic                  rd_valid;
  logic [WORD_SIZE-1:0]  shift_reg;
  logic [WORD_SIZE-1:0]  next_buf;
  logic [WORD_SIZE-1:0]  next_word;
  logic [CW-1:0]         bit_cnt;
  logic [BURST_SIZE-1:0] words_left;
  logic [BURST_SIZE-1:0] reads_left;

  // Short words can reach the word boundary on the same edge the prefetch data lands.
  assign next_word = rd_valid ? mem_rd_data : next_buf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rd_valid   <= 1'b0;
      shift_reg  <= '0;
      next_buf   <= '0;
      bit_cnt    <= '0;
      words_left <= '0;
      reads_left <= '0;
      mem_rd_en  <= 1'b0;
      mem_addr   <= '0;
      s_valid    <= 1'b0;
      tx_data    <= 1'b0;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      mem_rd_en <= 1'b0;
      tx_done   <= 1'b0;
      rd_valid  <= mem_rd_en;
      case (state)
        IDLE: begin
          if (start) begin
            mem_rd_en  <= 1'b1;
            mem_addr   <= start_addr;
            words_left <= (burst_size == '0) ? '0 : burst_size - ONE_B;
            reads_left <= (burst_size == '0) ? '0 : burst_size - ONE_B;
            busy       <= 1'b1;
            state      <= FETCH;
          end
        end
        FETCH: begin
          if (rd_valid) begin
            shift_reg <= mem_rd_data;
            s_valid   <= 1'b1;
            state     <= VALID;
          end
        end
        VALID: begin
          if (m_ready) begin
            s_valid   <= 1'b0;
            tx_data   <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= '0;
            state     <= SEND;
            if (reads_left != '0) begin
              mem_rd_en  <= 1'b1;
              mem_addr   <= mem_addr + ONE_A;
              reads_left <= reads_left - ONE_B;
            end
          end
        end
        SEND: begin
          if (rd_valid) next_buf <= mem_rd_data;
          if (bit_cnt != LAST_BIT) begin
            tx_data   <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= bit_cnt + 1'b1;
          end else if (words_left != '0) begin
            tx_data    <= next_word[0];
            shift_reg  <= next_word >> 1;
            bit_cnt    <= '0;
            words_left <= words_left - ONE_B;
            if (reads_left != '0) begin
              mem_rd_en  <= 1'b1;
              mem_addr   <= mem_addr + ONE_A;
              reads_left <= reads_left - ONE_B;
            end
          end else begin
            tx_data <= 1'b0;
            tx_done <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slave_out_port.sv
// Scoreboard bench for slave_out_port: expected bits and read addresses are queued at issue
// time; independent monitors pop and compare against tx_data, tx_done and the memory port.
`timescale 1ns/1ps
module tb_slave_out_port;
  localparam int W = 8;
  localparam int A = 12;
  localparam int B = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [A-1:0] start_addr;
  logic [B-1:0] burst_size;
  logic         mem_rd_en;
  logic [A-1:0] mem_addr;
  logic [W-1:0] mem_rd_data;
  logic         m_ready;
  logic         s_valid;
  logic         tx_data;
  logic         busy;
  logic         tx_done;

  logic [W-1:0] mem [0:(1<<A)-1];

  int n_vec    = 0;
  int n_err    = 0;
  int done_cnt = 0;
  int exp_done = 0;

  bit           exp_bits[$];
  int           exp_len[$];
  logic [A-1:0] exp_rd[$];

  always #5 clk = ~clk;

  slave_out_port #(.WORD_SIZE(W), .ADDR_WIDTH(A), .BURST_SIZE(B)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .burst_size(burst_size),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .m_ready(m_ready), .s_valid(s_valid), .tx_data(tx_data), .busy(busy), .tx_done(tx_done)
  );

  // slave memory, 1-cycle read latency
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (tx_done) done_cnt++;

  // read-port monitor
  always @(negedge clk) begin
    if (mem_rd_en) begin
      if (exp_rd.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL extra_read: got addr %0h expected no read at %0t", mem_addr, $time);
      end else begin
        chk("rd_addr", mem_addr, exp_rd.pop_front());
      end
    end
  end

  // serial monitor: a handshake edge starts one burst worth of bit compares
  initial begin
    forever begin
      @(posedge clk);
      if (s_valid && m_ready) begin
        int  n;
        bit  aborted;
        aborted = 1'b0;
        n = 0;
        if (exp_len.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_handshake: got handshake expected none at %0t", $time);
        end else begin
          n = exp_len.pop_front();
        end
        for (int i = 0; i < n; i++) begin
          @(negedge clk);
          if (rst) begin
            chk("reset_mid_burst", {s_valid, tx_data, mem_rd_en, busy, tx_done}, 0);
            for (int j = i; j < n; j++) void'(exp_bits.pop_front());
            aborted = 1'b1;
            break;
          end
          chk("tx_bit", tx_data, exp_bits.pop_front());
        end
        if (n > 0 && !aborted) begin
          @(negedge clk);
          chk("tx_done", tx_done, 1);
          chk("busy_end", busy, 0);
        end
      end
    end
  end

  // queue expectations, pulse start (called at a negedge), check start -> s_valid latency
  task automatic issue(input logic [A-1:0] addr, input logic [B-1:0] bs);
    int           len;
    logic [A-1:0] a;
    len = (bs == 0) ? 1 : int'(bs);
    for (int w = 0; w < len; w++) begin
      a = addr + A'(w);
      exp_rd.push_back(a);
      for (int b = 0; b < W; b++) exp_bits.push_back(mem[a][b]);
    end
    exp_len.push_back(len * W);
    start_addr = addr;
    burst_size = bs;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("lat_edge0", s_valid, 0);
    @(negedge clk);
    chk("lat_edge1", s_valid, 0);
    @(negedge clk);
    chk("lat_edge2", s_valid, 1);
  endtask

  task automatic wait_done(input int max);
    int c0;
    int k;
    c0 = done_cnt;
    k  = 0;
    while (done_cnt == c0 && k < max) begin
      @(negedge clk);
      k++;
    end
    if (done_cnt == c0) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: got no tx_done expected one within %0d cycles", max);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << A); i++) mem[i] = W'(i * 37 + 11);
    mem[12'h010] = 8'hA5;
    mem[12'h020] = 8'h01;
    mem[12'h021] = 8'h80;
    mem[12'h022] = 8'hFF;
    mem[12'hFFF] = 8'h3C;
    mem[12'h000] = 8'hC3;

    rst = 1'b1; start = 1'b0; start_addr = '0; burst_size = '0; m_ready = 1'b0;
    #12;
    chk("reset_outs", {s_valid, tx_data, mem_rd_en, busy, tx_done}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // single word 0xA5
    m_ready = 1'b1;
    issue(12'h010, 15'd1);
    wait_done(40);
    exp_done++;

    // three contiguous words
    issue(12'h020, 15'd3);
    wait_done(60);
    exp_done++;

    // master not ready for 50 cycles
    m_ready = 1'b0;
    issue(12'h030, 15'd2);
    repeat (50) @(negedge clk);
    chk("hold_valid", s_valid, 1);
    chk("hold_tx", tx_data, 0);
    chk("hold_busy", busy, 1);
    m_ready = 1'b1;
    wait_done(40);
    exp_done++;

    // address wrap, then burst_size 0
    issue(12'hFFF, 15'd2);
    wait_done(40);
    exp_done++;
    issue(12'h050, 15'd0);
    wait_done(40);
    exp_done++;

    // reset at word 2 bit 4 (overall bit 20, on tx_data after handshake edge + 20)
    issue(12'h020, 15'd3);
    repeat (21) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("async_reset", {s_valid, tx_data, mem_rd_en, busy, tx_done}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", {s_valid, busy, tx_done}, 0);
    issue(12'h010, 15'd1);
    wait_done(40);
    exp_done++;

    // start pulsed mid-burst must be ignored
    issue(12'h060, 15'd2);
    repeat (5) @(negedge clk);
    start_addr = 12'h300;
    burst_size = 15'd4;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(40);
    exp_done++;
    repeat (5) @(negedge clk);
    chk("ignored_start", {s_valid, busy}, 0);

    chk("reads_pending", exp_rd.size(), 0);
    chk("bits_pending", exp_bits.size(), 0);
    chk("done_count", done_cnt, exp_done);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
